fixed_point_div: RTL and testbench

Sequential signed fixed-point divider, the inverse of the datapath's `fixed_point_mult`, in the same Q(INT_WIDTH).(FRAC_WIDTH) sign-magnitude-range two's-complement format. It computes `result = (a << FRAC_WIDTH) / b` with a radix-2 restoring algorithm, one quotient bit per clock. It is used where GRU normalisation and scaling need a reciprocal or ratio. Operands enter and results leave over valid/ready handshakes, so the block can sit between pipelined stages.

---
 rtl/fixed_point_pkg.sv | 22 ++
 rtl/fixed_point_div_if.sv | 28 ++
 rtl/fixed_point_saturate.sv | 44 ++++
 rtl/fixed_point_div.sv | 161 ++++++++++++++++
 tb/tb_fixed_point_div.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point format definitions for the datapath arithmetic blocks
// (divider, multiplier). Values are Q(INT_WIDTH).(FRAC_WIDTH) two's complement
// with one sign bit, WIDTH bits in total.
package fixed_point_pkg;

   localparam int INT_WIDTH  = 8;
   localparam int FRAC_WIDTH = 8;
   localparam int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1;

   typedef logic signed [WIDTH-1:0] fixed_t;

   localparam fixed_t FIXED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam fixed_t FIXED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/fixed_point_div_if.sv
// Operand/result handshake bundle for fixed_point_div.
//   in_valid/in_ready/a/b           : operand pair, producer -> divider
//   out_valid/out_ready/result/flags : quotient, divider -> consumer
// slave  : divider side
// master : producer/consumer side
interface fixed_point_div_if #(
   parameter int WIDTH = fixed_point_pkg::WIDTH
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] a;
   logic signed [WIDTH-1:0] b;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] result;
   logic                    overflow;
   logic                    div_by_zero;

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, overflow, div_by_zero
   );

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, overflow, div_by_zero
   );
endinterface

// File: rtl/fixed_point_saturate.sv
// Combinational signed saturation: applies a sign to an unsigned magnitude and
// clamps to the WIDTH-bit two's-complement range.
//   i_mag      : unsigned magnitude (MAG_W >= WIDTH)
//   i_sign     : 1 = negative
//   o_result   : signed, saturated value
//   o_overflow : magnitude did not fit and was clamped
module fixed_point_saturate
   import fixed_point_pkg::*;
#(
   parameter int WIDTH = fixed_point_pkg::WIDTH,
   parameter int MAG_W = fixed_point_pkg::WIDTH
) (
   input  logic [MAG_W-1:0]        i_mag,
   input  logic                    i_sign,
   output logic signed [WIDTH-1:0] o_result,
   output logic                    o_overflow
);

   localparam logic [MAG_W-1:0] POS_LIM = MAG_W'({1'b0, {(WIDTH-1){1'b1}}});
   localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'({1'b1, {(WIDTH-1){1'b0}}});
   localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] w_mag_lo;

   assign w_mag_lo = i_mag[WIDTH-1:0];

   always_comb begin
      o_overflow = 1'b0;
      if (!i_sign && (i_mag > POS_LIM)) begin
         o_result   = S_MAX;
         o_overflow = 1'b1;
      end else if (i_sign && (i_mag > NEG_LIM)) begin
         o_result   = S_MIN;
         o_overflow = 1'b1;
      end else if (i_sign) begin
         // magnitude 2^(WIDTH-1) negates onto itself, which is exactly S_MIN
         o_result = $signed(~w_mag_lo + 1'b1);
      end else begin
         o_result = $signed(w_mag_lo);
      end
   end

endmodule

// File: rtl/fixed_point_div.sv
// Sequential signed fixed-point divider, result = (a << FRAC_WIDTH) / b.
// Radix-2 restoring division on magnitudes, one quotient bit per clock,
// then sign/saturate. Operands and result move over valid/ready handshakes.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fixed_point_div_if.slave (operands in, quotient + flags out)
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// CALC  | N restoring iterations, one quotient bit per edge
// FIX   | apply sign, saturate or divide-by-zero value, register outputs
// DONE  | out_valid=1, holding outputs until out_ready
module fixed_point_div
   import fixed_point_pkg::*;
#(
   parameter int INT_WIDTH  = fixed_point_pkg::INT_WIDTH,
   parameter int FRAC_WIDTH = fixed_point_pkg::FRAC_WIDTH,
   parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1
) (
   input logic              clk,
   input logic              rst_n,
   fixed_point_div_if.slave bus
);

   localparam int N  = WIDTH + FRAC_WIDTH;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t r_state, w_state_nxt;

   logic                    r_in_ready, r_out_valid;
   logic                    w_in_ready_nxt, w_out_valid_nxt;
   logic signed [WIDTH-1:0] r_result;
   logic                    r_overflow, r_div_by_zero;

   logic                    r_sign, r_a_neg, r_dz_pend;
   logic [N-1:0]            r_dvd;
   logic [WIDTH-1:0]        r_dvs;
   logic [WIDTH-1:0]        r_rem;
   logic [CW-1:0]           r_cnt;

   logic                    w_accept, w_b_zero;
   logic [WIDTH-1:0]        w_abs_a, w_abs_b;
   logic [WIDTH:0]          w_rem_sh;
   logic                    w_ge;
   logic [WIDTH-1:0]        w_rem_sub;
   logic signed [WIDTH-1:0] w_sat_res;
   logic                    w_sat_ovf;

   assign w_accept = (r_state == IDLE) && bus.in_valid;
   assign w_b_zero = (bus.b == '0);

   // Magnitudes taken as WIDTH-bit unsigned so |-2^(WIDTH-1)| is representable
   assign w_abs_a = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
   assign w_abs_b = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

   // Remainder stays below |b| <= 2^(WIDTH-1); one extra bit covers the shift
   assign w_rem_sh  = {r_rem, r_dvd[N-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
   assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_dvs;

   fixed_point_saturate #(
      .WIDTH (WIDTH),
      .MAG_W (N)
   ) u_sat (
      .i_mag      (r_dvd),
      .i_sign     (r_sign),
      .o_result   (w_sat_res),
      .o_overflow (w_sat_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_nxt = w_b_zero ? FIX : CALC;
         CALC: if (r_cnt == LAST) w_state_nxt = FIX;
         FIX:  w_state_nxt = DONE;
         DONE: if (bus.out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_in_ready_nxt  = 1'b0;
      w_out_valid_nxt = 1'b0;
      case (r_state)
         IDLE: w_in_ready_nxt = !w_accept;
         FIX:  w_out_valid_nxt = 1'b1;
         DONE: begin
            w_in_ready_nxt  = bus.out_ready;
            w_out_valid_nxt = !bus.out_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign        <= 1'b0;
         r_a_neg       <= 1'b0;
         r_dz_pend     <= 1'b0;
         r_dvd         <= '0;
         r_dvs         <= '0;
         r_rem         <= '0;
         r_cnt         <= '0;
         r_result      <= '0;
         r_overflow    <= 1'b0;
         r_div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_sign    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
               r_a_neg   <= bus.a[WIDTH-1];
               r_dz_pend <= w_b_zero;
               r_dvd     <= {w_abs_a, {FRAC_WIDTH{1'b0}}};
               r_dvs     <= w_abs_b;
               r_rem     <= '0;
               r_cnt     <= '0;
            end
            CALC: begin
               r_rem <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
               r_dvd <= {r_dvd[N-2:0], w_ge};
               r_cnt <= r_cnt + 1'b1;
            end
            FIX: begin
               if (r_dz_pend) begin
                  r_result      <= r_a_neg ? S_MIN : S_MAX;
                  r_overflow    <= 1'b0;
                  r_div_by_zero <= 1'b1;
               end else begin
                  r_result      <= w_sat_res;
                  r_overflow    <= w_sat_ovf;
                  r_div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.result      = r_result;
   assign bus.overflow    = r_overflow;
   assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_fixed_point_div.sv
// Directed bench for fixed_point_div: expected quotients/flags/latencies are
// queued at operand acceptance and compared when out_valid appears.
module tb_fixed_point_div;
   import fixed_point_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_err;

   typedef struct {
      int res;
      bit ovf;
      bit dz;
      int lat;
   } exp_t;

   exp_t sb[$];

   fixed_point_div_if #(.WIDTH(WIDTH)) bus ();

   fixed_point_div u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic accept(input int ta, input int tb_, input int er, input bit eo, input bit ed, input int el);
      exp_t e;
      int   k;
      k = 0;
      while (!bus.in_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
      e.res = er; e.ovf = eo; e.dz = ed; e.lat = el;
      sb.push_back(e);
      bus.a        = fixed_t'(ta);
      bus.b        = fixed_t'(tb_);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Called #1 after the accepting edge: waits for out_valid, checks the
   // popped expectation, optionally back-pressures, then completes handshake.
   task automatic collect(input int hold);
      exp_t e;
      int   lat;
      logic signed [WIDTH-1:0] held;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("latency", lat, e.lat);
         chk("result", bus.result, e.res);
         chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
         chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
      end
      held = bus.result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_result", bus.result, held);
         chk("hold_in_ready", {31'd0, bus.in_ready}, 0);
         chk("hold_out_valid", {31'd0, bus.out_valid}, 1);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("post_hs_out_valid", {31'd0, bus.out_valid}, 0);
      chk("post_hs_in_ready", {31'd0, bus.in_ready}, 1);
   endtask

   initial begin
      int seen;
      n_checks      = 0;
      n_err         = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_overflow", {31'd0, bus.overflow}, 0);
      chk("rst_div_by_zero", {31'd0, bus.div_by_zero}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic quotient and signs / truncation
      accept(768, 512, 384, 0, 0, 26);        collect(0);
      accept(-768, 512, -384, 0, 0, 26);      collect(0);
      accept(1, 768, 0, 0, 0, 26);            collect(0);
      accept(-1, 768, 0, 0, 0, 26);           collect(0);
      accept(256, -1024, -64, 0, 0, 26);      collect(0);

      // saturation boundaries
      accept(65535, 1, 65535, 1, 0, 26);      collect(0);
      accept(-65536, -256, 65535, 1, 0, 26);  collect(0);
      accept(-65536, 256, -65536, 0, 0, 26);  collect(0);

      // divide by zero
      accept(100, 0, 65535, 0, 1, 1);         collect(0);
      accept(-5, 0, -65536, 0, 1, 1);         collect(0);
      accept(0, 0, 65535, 0, 1, 1);           collect(0);

      // back-pressure: out_ready low for 10 cycles
      accept(768, 512, 384, 0, 0, 26);        collect(10);

      // in_valid held high with new operands: second accepted only after handshake
      sb.push_back('{res: 384, ovf: 0, dz: 0, lat: 26});
      bus.a = 17'sd768; bus.b = 17'sd512; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_first_accept_in_ready", {31'd0, bus.in_ready}, 0);
      bus.a = -17'sd768; bus.b = 17'sd512;
      sb.push_back('{res: -384, ovf: 0, dz: 0, lat: 26});
      collect(0);
      @(posedge clk); #1;
      chk("b2b_second_accept_in_ready", {31'd0, bus.in_ready}, 0);
      bus.in_valid = 1'b0;
      collect(0);

      // reset during CALC at iteration 10
      bus.a = 17'sd768; bus.b = 17'sd512; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", {31'd0, bus.in_ready}, 1);
      chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      chk("midrst_no_stale_result", seen, 0);
      accept(-768, -512, 384, 0, 0, 26);      collect(0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
